// File: rtl/esm_pkg.sv
// esm_pkg: shared FSM state encoding and LFSR polynomial for the issue picker.
package esm_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DRAW, OFFER} state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/esm_lfsr.sv
// esm_lfsr: right-shifting Galois LFSR, reloads SEED on reset.
module esm_lfsr import esm_pkg::*; #(
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(32'hACE1_0001)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] value_q, value_d;

    always_comb value_d = !en ? value_q :
                          value_q[0] ? (value_q >> 1) ^ LFSR_W'(LFSR_POLY) : value_q >> 1;

    always_ff @(posedge clk or posedge rst)
        if (rst) value_q <= SEED;
        else     value_q <= value_d;

    assign value = value_q;

endmodule

// File: rtl/esm_issue_picker.sv
// esm_issue_picker: candidate bitmap with a scan/draw FSM that offers one
// pseudo-randomly chosen set slot per request.
module esm_issue_picker import esm_pkg::*; #(
    parameter int                BS     = 16,
    parameter int                IW     = $clog2(BS),
    parameter int                LFSR_W = 32,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(32'hACE1_0001)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ins_valid,
    input  logic [IW-1:0] ins_index,
    input  logic          pick_req,
    output logic          pick_valid,
    output logic [IW-1:0] pick_index,
    input  logic          pick_ready,
    output logic [IW:0]   cand_count,
    output logic          empty,
    output logic          busy
);

    state_e            state_q, state_d;
    logic [BS-1:0]     bitmap_q, bitmap_d;
    logic [IW-1:0]     tbl_q [BS];
    logic [IW-1:0]     tbl_d [BS];
    logic [IW:0]       tcount_q, tcount_d, retry_q, retry_d, cand_count_q, cand_count_d;
    logic [IW-1:0]     scan_ptr_q, scan_ptr_d, pick_index_q, pick_index_d;
    logic [LFSR_W-1:0] lfsr;
    logic [IW-1:0]     r;
    logic              unused_lfsr_hi;

    esm_lfsr #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .value (lfsr)
    );

    assign r              = lfsr[IW-1:0];
    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:IW];

    always_comb begin
        state_d      = state_q;
        bitmap_d     = bitmap_q;
        tbl_d        = tbl_q;
        tcount_d     = tcount_q;
        retry_d      = retry_q;
        scan_ptr_d   = scan_ptr_q;
        pick_index_d = pick_index_q;
        case (state_q)
            IDLE: if (pick_req && |bitmap_q) begin
                state_d    = SCAN;
                scan_ptr_d = '0;
                tcount_d   = '0;
            end
            SCAN: begin
                if (bitmap_q[scan_ptr_q]) begin
                    tbl_d[tcount_q[IW-1:0]] = scan_ptr_q;
                    tcount_d                = tcount_q + 1'b1;
                end
                scan_ptr_d = scan_ptr_q + 1'b1;
                if (scan_ptr_q == IW'(BS - 1)) begin
                    state_d = DRAW;
                    retry_d = '0;
                end
            end
            // Rejection sampling; after BS misses fall back to the first entry.
            DRAW: if ({1'b0, r} < tcount_q) begin
                pick_index_d = tbl_q[r];
                state_d      = OFFER;
            end else if (retry_q == (IW+1)'(BS)) begin
                pick_index_d = tbl_q[0];
                state_d      = OFFER;
            end else begin
                retry_d = retry_q + 1'b1;
            end
            OFFER: if (pick_ready) begin
                bitmap_d[pick_index_q] = 1'b0;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (ins_valid) bitmap_d[ins_index] = 1'b1;
        cand_count_d = '0;
        for (int i = 0; i < BS; i++) cand_count_d = cand_count_d + (IW+1)'(bitmap_d[i]);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q      <= IDLE;
            bitmap_q     <= '0;
            tbl_q        <= '{default: '0};
            tcount_q     <= '0;
            retry_q      <= '0;
            scan_ptr_q   <= '0;
            pick_index_q <= '0;
            cand_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bitmap_q     <= bitmap_d;
            tbl_q        <= tbl_d;
            tcount_q     <= tcount_d;
            retry_q      <= retry_d;
            scan_ptr_q   <= scan_ptr_d;
            pick_index_q <= pick_index_d;
            cand_count_q <= cand_count_d;
        end

    assign pick_valid = state_q == OFFER;
    assign pick_index = pick_index_q;
    assign cand_count = cand_count_q;
    assign empty      = cand_count_q == '0;
    assign busy       = state_q != IDLE;

endmodule

// File: tb/tb_esm_issue_picker.sv
// tb_esm_issue_picker: directed stimulus with a pick scoreboard checked by a negedge monitor.
module tb_esm_issue_picker;

    localparam int BS = 16;
    localparam int IW = 4;

    logic          clk = 1'b0, rst = 1'b0, ins_valid = 1'b0, pick_req = 1'b0, pick_ready = 1'b1;
    logic [IW-1:0] ins_index = '0;
    logic          pick_valid, empty, busy;
    logic [IW-1:0] pick_index;
    logic [IW:0]   cand_count;

    esm_issue_picker #(.BS(BS)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_index  (ins_index),
        .pick_req   (pick_req),
        .pick_valid (pick_valid),
        .pick_index (pick_index),
        .pick_ready (pick_ready),
        .cand_count (cand_count),
        .empty      (empty),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BS-1:0] mask;
        int            req_cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            checks = 0, failures = 0, picks_done = 0, lat;
    logic [IW-1:0] last_pick = '0, held = '0;
    logic [BS-1:0] model = '0;
    logic          prev_valid = 1'b0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: latency and membership on offer, index stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_valid = 1'b0;
        end else begin
            if (pick_valid && !prev_valid) begin
                if (sb.size() == 0) chk("unexpected_offer", 1, 0);
                else begin
                    lat = cyc - sb[0].req_cyc;
                    checks++;
                    if (lat < BS + 1 || lat > 2 * BS + 1) begin
                        failures++;
                        $display("FAIL pick_latency actual=%0d required=%0d..%0d", lat, BS + 1, 2 * BS + 1);
                    end
                end
                held = pick_index;
            end else if (pick_valid) chk("index_stable", int'(pick_index), int'(held));
            if (pick_valid && pick_ready && sb.size() > 0) begin
                e = sb.pop_front();
                chk("pick_in_set", int'(e.mask[pick_index]), 1);
                last_pick = pick_index;
                picks_done++;
            end
            prev_valid = pick_valid;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic insert(int idx);
        ins_valid = 1'b1;
        ins_index = IW'(idx);
        tick();
        ins_valid = 1'b0;
        model[idx] = 1'b1;
    endtask

    task automatic issue();
        sb.push_back('{mask: model, req_cyc: cyc + 1});
        pick_req = 1'b1;
        tick();
        pick_req = 1'b0;
    endtask

    task automatic wait_done(int start);
        int n = 0;
        while (picks_done == start && n < 100) begin
            tick();
            n++;
        end
        chk("pick_done_timeout", int'(picks_done != start), 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!pick_valid && n < 100) begin
            tick();
            n++;
        end
        chk("valid_timeout", int'(pick_valid), 1);
    endtask

    task automatic do_pick();
        int s = picks_done;
        issue();
        wait_done(s);
        model[last_pick] = 1'b0;
        tick(2);
        chk("cand_count", int'(cand_count), $countones(model));
    endtask

    initial begin
        int s, k;
        rst = 1'b1;
        tick(2);
        chk("rst_pick_valid", int'(pick_valid), 0);
        chk("rst_pick_index", int'(pick_index), 0);
        chk("rst_cand_count", int'(cand_count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        pick_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("empty_pick_busy", int'(busy), 0);
            chk("empty_pick_valid", int'(pick_valid), 0);
        end
        pick_req = 1'b0;

        insert(5);
        tick(2);
        chk("single_cand", int'(cand_count), 1);
        chk("single_not_empty", int'(empty), 0);
        do_pick();
        chk("single_idx", int'(last_pick), 5);
        chk("single_empty", int'(empty), 1);

        for (int i = 0; i < BS; i++) insert(i);
        tick(2);
        chk("full_cand", int'(cand_count), BS);
        repeat (BS) do_pick();
        chk("full_empty", int'(empty), 1);

        insert(3);
        insert(9);
        tick(2);
        pick_ready = 1'b0;
        s = picks_done;
        issue();
        wait_valid();
        tick(20);
        chk("bp_cand", int'(cand_count), 2);
        chk("bp_valid", int'(pick_valid), 1);
        pick_ready = 1'b1;
        wait_done(s);
        model[last_pick] = 1'b0;
        tick(2);
        chk("bp_after_cand", int'(cand_count), 1);

        k = model[3] ? 3 : 9;
        pick_ready = 1'b0;
        s = picks_done;
        issue();
        wait_valid();
        chk("coll_idx", int'(pick_index), k);
        ins_valid = 1'b1;
        ins_index = IW'(k);
        pick_ready = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick(2);
        chk("coll_done", int'(picks_done), s + 1);
        chk("coll_cand", int'(cand_count), 1);
        chk("coll_busy", int'(busy), 0);
        do_pick();
        chk("coll_repick", int'(last_pick), k);

        insert(7);
        tick(2);
        pick_ready = 1'b0;
        issue();
        wait_valid();
        rst = 1'b1;
        #1;
        chk("rst_offer_valid", int'(pick_valid), 0);
        chk("rst_offer_empty", int'(empty), 1);
        chk("rst_offer_busy", int'(busy), 0);
        chk("rst_offer_index", int'(pick_index), 0);
        tick(2);
        rst = 1'b0;
        model = '0;
        pick_ready = 1'b1;
        tick(2);
        chk("post_rst_cand", int'(cand_count), 0);
        pick_req = 1'b1;
        tick(5);
        chk("post_rst_busy", int'(busy), 0);
        pick_req = 1'b0;

        insert(12);
        tick(2);
        do_pick();
        chk("post_rst_idx", int'(last_pick), 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/esm_issue_picker.md
ESM_ISSUE_PICKER -- requirements
Module: esm_issue_picker

Interface
REQ-001 Parameter BS, default 16, number of issue slots; SHALL be a power of two, >= 2.
REQ-002 Parameter IW, default $clog2(BS), slot index width.
REQ-003 Parameter LFSR_W, default 32, PRNG state width.
REQ-004 Parameter SEED, default 32'hACE1_0001, LFSR reset value; SHALL be nonzero.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ins_valid  in  1  insert request for the candidate bitmap.
REQ-008 ins_index  in  IW  slot to mark as candidate.
REQ-009 pick_req  in  1  request one random candidate.
REQ-010 pick_valid  out  1  picked index available.
REQ-011 pick_index  out  IW  picked slot index.
REQ-012 pick_ready  in  1  consumer accepts pick.
REQ-013 cand_count  out  IW+1  live number of set bitmap bits, registered.
REQ-014 empty  out  1  cand_count == 0.
REQ-015 busy  out  1  FSM not in IDLE.

Function
REQ-016 Bitmap bit ins_index SHALL be set one cycle after ins_valid, in every FSM state; inserting an already-set bit is a no-op.
REQ-017 FSM states IDLE, SCAN, DRAW, OFFER.
REQ-018 IDLE: pick_req with bitmap nonzero -> SCAN (scan_ptr=0, tcount=0); pick_req with empty bitmap SHALL be ignored (stay IDLE, no pick_valid).
REQ-019 SCAN: one slot per cycle; if bitmap[scan_ptr] then table[tcount]=scan_ptr, tcount++; after scan_ptr=BS-1 -> DRAW; exactly BS cycles.
REQ-020 Inserts during SCAN for slots already passed SHALL NOT enter the table; they apply to the next pick.
REQ-021 DRAW: r = lfsr[IW-1:0]; r < tcount -> latch table[r] into pick_index, -> OFFER; else retry next cycle.
REQ-022 DRAW SHALL bound retries: after BS consecutive rejections, latch table[0] and -> OFFER.
REQ-023 OFFER: pick_valid=1, pick_index stable until pick_ready; on handshake clear bitmap[pick_index], -> IDLE.
REQ-024 Insert and handshake-clear of the same index in one cycle: insert wins, bit stays set.
REQ-025 LFSR: Galois, polynomial 32'h8020_0003, advances every cycle out of reset independent of FSM state.
REQ-026 cand_count SHALL reflect bitmap after each update with 1-cycle latency; width IW+1 so BS candidates is representable.
REQ-027 Pick latency from pick_req (IDLE) to pick_valid: BS+1 cycles minimum, 2*BS+1 maximum.

Reset
REQ-028 rst SHALL asynchronously clear bitmap, table, tcount, scan_ptr, retry counter, pick_index; FSM -> IDLE; LFSR <= SEED.
REQ-029 Outputs during/after reset: pick_valid=0, pick_index=0, cand_count=0, empty=1, busy=0.
REQ-030 rst asserted mid-SCAN/DRAW/OFFER SHALL abort the pick; no bitmap bit is cleared by an aborted pick.

Structure
REQ-031 Package esm_pkg SHALL hold the FSM state enum and the LFSR polynomial constant.
REQ-032 The LFSR SHALL be a sub-module esm_lfsr (params LFSR_W, SEED; ports clk, rst, en, value).

Verification
REQ-033 Reset: assert rst mid-OFFER -> pick_valid=0, empty=1, busy=0 same cycle; bitmap cleared.
REQ-034 Single candidate: insert 5, pick_req -> pick_valid after BS+1..2*BS+1 cycles, pick_index=5; after handshake cand_count=0.
REQ-035 Empty pick: pick_req with empty=1 for 10 cycles -> busy stays 0, pick_valid never 1.
REQ-036 Full set: insert 0..15, 16 picks -> 16 distinct indices, cand_count decrements 16->0.
REQ-037 Backpressure: hold pick_ready=0 for 20 cycles in OFFER -> pick_index unchanged, bitmap unchanged.
REQ-038 Collision: in OFFER with pick_index=k, ins_valid with ins_index=k on handshake cycle -> bitmap[k]=1, cand_count unchanged.
